// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage MIPS-style pipeline.
// Tracks the producers sitting in E, M and W, raises a single stall/flush
// request for load-use, early-compare and HI/LO busy hazards, and selects
// bypass paths for operands consumed in D and in E. The multiply/divide unit
// is modelled by a busy countdown (md_cnt); MUL_LAT and DIV_LAT must fit in
// CNTW bits.
// Build option: define HAZARD_FWD_EN to enable bypassing. When it is not
// defined, all bypass selects are 00 and any used source that matches a
// producer in E, M or W stalls until that producer has retired.
module hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNTW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs_d,
  input  logic [AW-1:0]   rt_d,
  input  logic            use_rs_d,
  input  logic            use_rt_d,
  input  logic            early_rs_d,
  input  logic            early_rt_d,
  input  logic            issue_d,
  input  logic            wr_d,
  input  logic [AW-1:0]   wd_d,
  input  logic [1:0]      cls_d,
  input  logic            md_start_d,
  input  logic            md_op_d,
  input  logic            md_use_d,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_e,
  output logic [1:0]      fwd_a_d,
  output logic [1:0]      fwd_b_d,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic            md_busy,
  output logic [CNTW-1:0] md_cnt
);

  localparam logic [1:0]      CLS_LOAD = 2'd1;
  localparam logic [1:0]      CLS_LINK = 2'd2;
  localparam logic [CNTW-1:0] MUL_CNT  = CNTW'(MUL_LAT);
  localparam logic [CNTW-1:0] DIV_CNT  = CNTW'(DIV_LAT);

  // Shadow copies of the instructions in E, M and W
  logic          e_vld, m_vld, w_vld;
  logic          e_wr, m_wr, w_wr;
  logic [AW-1:0] e_wd, m_wd, w_wd;
  logic [1:0]    e_cls, m_cls, w_cls;
  logic [AW-1:0] e_rs, e_rt;
  logic          e_use_rs, e_use_rt;

  logic hazard, data_haz, md_haz;
  logic ea_d, ma_d, wa_d, eb_d, mb_d, wb_d;

  // A producer supplies a source when it is live, writes, and targets that
  // (nonzero) register; $0 never creates a dependency.
  function automatic logic hit(input logic vld, input logic wr,
                               input logic [AW-1:0] wd, input logic [AW-1:0] src);
    return vld && wr && (wd == src) && (src != '0);
  endfunction

  assign ea_d = use_rs_d && hit(e_vld, e_wr, e_wd, rs_d);
  assign ma_d = use_rs_d && hit(m_vld, m_wr, m_wd, rs_d);
  assign wa_d = use_rs_d && hit(w_vld, w_wr, w_wd, rs_d);
  assign eb_d = use_rt_d && hit(e_vld, e_wr, e_wd, rt_d);
  assign mb_d = use_rt_d && hit(m_vld, m_wr, m_wd, rt_d);
  assign wb_d = use_rt_d && hit(w_vld, w_wr, w_wd, rt_d);

`ifdef HAZARD_FWD_EN
  logic ma_e, wa_e, mb_e, wb_e;

  // Early operands (branch compare, jr) cannot wait for an ALU result still
  // in E or a load still in M; late operands only block on a load in E.
  function automatic logic src_haz(input logic early, input logic he,
                                   input logic hm, input logic [1:0] ecls,
                                   input logic [1:0] mcls);
    if (early) return (he && ecls != CLS_LINK) || (hm && mcls == CLS_LOAD);
    else       return he && ecls == CLS_LOAD;
  endfunction

  // Youngest usable producer wins; a link address is valid as soon as the
  // jal enters E, a load value only once it has left M.
  function automatic logic [1:0] sel_d(input logic he, input logic hm,
                                       input logic hw, input logic [1:0] ecls,
                                       input logic [1:0] mcls);
    if (he && ecls == CLS_LINK)      return 2'b11;
    else if (hm && mcls != CLS_LOAD) return 2'b10;
    else if (hw)                     return 2'b01;
    else                             return 2'b00;
  endfunction

  function automatic logic [1:0] sel_e(input logic hm, input logic hw,
                                       input logic [1:0] mcls);
    if (hm && mcls != CLS_LOAD) return 2'b10;
    else if (hw)                return 2'b01;
    else                        return 2'b00;
  endfunction

  assign ma_e = e_vld && e_use_rs && hit(m_vld, m_wr, m_wd, e_rs);
  assign wa_e = e_vld && e_use_rs && hit(w_vld, w_wr, w_wd, e_rs);
  assign mb_e = e_vld && e_use_rt && hit(m_vld, m_wr, m_wd, e_rt);
  assign wb_e = e_vld && e_use_rt && hit(w_vld, w_wr, w_wd, e_rt);

  assign data_haz = src_haz(early_rs_d, ea_d, ma_d, e_cls, m_cls) ||
                    src_haz(early_rt_d, eb_d, mb_d, e_cls, m_cls);
  assign fwd_a_d  = sel_d(ea_d, ma_d, wa_d, e_cls, m_cls);
  assign fwd_b_d  = sel_d(eb_d, mb_d, wb_d, e_cls, m_cls);
  assign fwd_a_e  = sel_e(ma_e, wa_e, m_cls);
  assign fwd_b_e  = sel_e(mb_e, wb_e, m_cls);
`else
  logic unused_nofwd;

  assign data_haz = ea_d || ma_d || wa_d || eb_d || mb_d || wb_d;
  assign fwd_a_d  = 2'b00;
  assign fwd_b_d  = 2'b00;
  assign fwd_a_e  = 2'b00;
  assign fwd_b_e  = 2'b00;
  assign unused_nofwd = ^{early_rs_d, early_rt_d, e_cls, m_cls, e_rs, e_rt,
                          e_use_rs, e_use_rt};
`endif

  logic unused_wcls;
  assign unused_wcls = ^w_cls;

  assign md_busy = (md_cnt != '0);
  assign md_haz  = md_busy && (md_start_d || md_use_d) && issue_d;
  assign hazard  = data_haz || md_haz;
  assign stall_f = hazard;
  assign stall_d = hazard;
  assign flush_e = hazard;

  // Valid bits advance every cycle; a stall injects a bubble into E
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld <= 1'b0;
      m_vld <= 1'b0;
      w_vld <= 1'b0;
    end else begin
      e_vld <= issue_d && !hazard;
      m_vld <= e_vld;
      w_vld <= m_vld;
    end
  end

  // Payload fields follow the valid bits; they are ignored while invalid
  always_ff @(posedge clk) begin
    e_wr     <= wr_d;
    e_wd     <= wd_d;
    e_cls    <= cls_d;
    e_rs     <= rs_d;
    e_rt     <= rt_d;
    e_use_rs <= use_rs_d;
    e_use_rt <= use_rt_d;
    m_wr     <= e_wr;
    m_wd     <= e_wd;
    m_cls    <= e_cls;
    w_wr     <= m_wr;
    w_wd     <= m_wd;
    w_cls    <= m_cls;
  end

  // MDU busy countdown: loaded when a mul/div actually issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (md_start_d && issue_d && !hazard) begin
      md_cnt <= md_op_d ? DIV_CNT : MUL_CNT;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Expectations for the bypass build
// (HAZARD_FWD_EN defined) and the stall-only build are selected with the
// same macro as the design.
module tb_hazard_scoreboard;

  localparam logic [1:0] ALU  = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] LINK = 2'd2;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, wd_d;
  logic       use_rs_d, use_rt_d, early_rs_d, early_rt_d;
  logic       issue_d, wr_d;
  logic [1:0] cls_d;
  logic       md_start_d, md_op_d, md_use_d;
  logic       stall_f, stall_d, flush_e;
  logic [1:0] fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
  logic       md_busy;
  logic [3:0] md_cnt;

  int checks;
  int failures;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d),
    .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .early_rs_d(early_rs_d), .early_rt_d(early_rt_d),
    .issue_d(issue_d), .wr_d(wr_d), .wd_d(wd_d), .cls_d(cls_d),
    .md_start_d(md_start_d), .md_op_d(md_op_d), .md_use_d(md_use_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .md_busy(md_busy), .md_cnt(md_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic iss, input logic [4:0] rs, input logic urs,
                     input logic ers, input logic [4:0] rt, input logic urt,
                     input logic ert, input logic wr, input logic [4:0] wd,
                     input logic [1:0] cls);
    issue_d = iss;  rs_d = rs; use_rs_d = urs; early_rs_d = ers;
    rt_d = rt; use_rt_d = urt; early_rt_d = ert;
    wr_d = wr; wd_d = wd; cls_d = cls;
    md_start_d = 1'b0; md_op_d = 1'b0; md_use_d = 1'b0;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, ALU);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    nop();
    #3;
    chk("rst_stall_f", stall_f, 0);
    chk("rst_flush_e", flush_e, 0);
    chk("rst_fwd_a_d", fwd_a_d, 0);
    chk("rst_fwd_b_d", fwd_b_d, 0);
    chk("rst_fwd_a_e", fwd_a_e, 0);
    chk("rst_fwd_b_e", fwd_b_e, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_md_cnt", md_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef HAZARD_FWD_EN
    // ALU $8 followed by two late users
    drv(1, 0, 0, 0, 0, 0, 0, 1, 8, ALU);
    #2 chk("alu_issue_stall", stall_d, 0);
    tick();
    drv(1, 8, 1, 0, 8, 1, 0, 0, 0, ALU);
    #2 chk("alu_use_nostall", stall_f, 0);
    tick();
    drv(1, 8, 1, 0, 0, 0, 0, 0, 0, ALU);
    #2 chk("alu_fwd_a_e_m", fwd_a_e, 2);
    chk("alu_fwd_b_e_m", fwd_b_e, 2);
    chk("alu_fwd_a_d_m", fwd_a_d, 2);
    tick();
    nop();
    #2 chk("alu_fwd_a_e_w", fwd_a_e, 1);
    chk("alu_fwd_b_e_unused", fwd_b_e, 0);
    drain();

    // LOAD $9 then late use: one bubble, value later taken from W
    drv(1, 0, 0, 0, 0, 0, 0, 1, 9, LOAD);
    tick();
    drv(1, 9, 1, 0, 0, 0, 0, 0, 0, ALU);
    #2 chk("ld_late_stall_f", stall_f, 1);
    chk("ld_late_stall_d", stall_d, 1);
    chk("ld_late_flush_e", flush_e, 1);
    tick();
    #2 chk("ld_late_release", stall_d, 0);
    chk("ld_late_fwd_a_d", fwd_a_d, 0);
    tick();
    nop();
    #2 chk("ld_late_fwd_a_e", fwd_a_e, 1);
    drain();

    // LOAD $9 then beq on $9: two bubbles, then bypass from W
    drv(1, 0, 0, 0, 0, 0, 0, 1, 9, LOAD);
    tick();
    drv(1, 9, 1, 1, 0, 0, 0, 0, 0, ALU);
    #2 chk("ld_early_stall1", stall_f, 1);
    tick();
    #2 chk("ld_early_stall2", stall_f, 1);
    tick();
    #2 chk("ld_early_release", stall_f, 0);
    chk("ld_early_fwd_a_d", fwd_a_d, 1);
    tick();
    drain();

    // jal then jr $31: link value bypassed from E, then from M
    drv(1, 0, 0, 0, 0, 0, 0, 1, 31, LINK);
    tick();
    drv(1, 31, 1, 1, 0, 0, 0, 0, 0, ALU);
    #2 chk("jr_stall", stall_f, 0);
    chk("jr_fwd_a_d_e", fwd_a_d, 3);
    tick();
    #2 chk("jr2_stall", stall_f, 0);
    chk("jr2_fwd_a_d_m", fwd_a_d, 2);
    tick();
    drain();

    // Two writers of $10: the younger one must be selected in E
    drv(1, 0, 0, 0, 0, 0, 0, 1, 10, ALU);
    tick();
    tick();
    drv(1, 10, 1, 0, 0, 0, 0, 0, 0, ALU);
    #2 chk("young_stall", stall_f, 0);
    tick();
    nop();
    #2 chk("young_fwd_a_e", fwd_a_e, 2);
    drain();

    // Early rt against an ALU result: stall while in E, bypass from M
    drv(1, 0, 0, 0, 0, 0, 0, 1, 12, ALU);
    tick();
    drv(1, 0, 0, 0, 12, 1, 1, 0, 0, ALU);
    #2 chk("rt_early_stall", stall_d, 1);
    tick();
    #2 chk("rt_early_release", stall_d, 0);
    chk("rt_early_fwd_b_d", fwd_b_d, 2);
    tick();
    drain();

    // Register 0 never hazards or forwards
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0, LOAD);
    tick();
    drv(1, 0, 1, 1, 0, 1, 0, 0, 0, ALU);
    #2 chk("r0_stall", stall_f, 0);
    chk("r0_fwd_a_d", fwd_a_d, 0);
    chk("r0_fwd_b_d", fwd_b_d, 0);
    tick();
    drain();
`else
    // ALU $8 then use: stall until the producer has left W
    drv(1, 0, 0, 0, 0, 0, 0, 1, 8, ALU);
    tick();
    drv(1, 8, 1, 0, 0, 0, 0, 0, 0, ALU);
    for (int i = 0; i < 3; i++) begin
      #2 chk("nf_alu_stall", stall_f, 1);
      chk("nf_alu_fwd_a_d", fwd_a_d, 0);
      chk("nf_alu_fwd_a_e", fwd_a_e, 0);
      tick();
    end
    #2 chk("nf_alu_release", stall_f, 0);
    chk("nf_alu_flush_rel", flush_e, 0);
    chk("nf_alu_fwd_b_d", fwd_b_d, 0);
    tick();
    drain();

    // Matching but unused source does not stall; used rt does
    drv(1, 0, 0, 0, 0, 0, 0, 1, 12, ALU);
    tick();
    drv(1, 12, 0, 0, 12, 0, 0, 0, 0, ALU);
    #2 chk("nf_unused_stall", stall_f, 0);
    drv(1, 0, 0, 0, 12, 1, 0, 0, 0, ALU);
    #2 chk("nf_rt_stall", stall_d, 1);
    chk("nf_rt_flush", flush_e, 1);
    drain();

    // Producer only in W still stalls
    drv(1, 0, 0, 0, 0, 0, 0, 1, 13, LOAD);
    tick();
    nop();
    tick();
    tick();
    drv(1, 13, 1, 0, 0, 0, 0, 0, 0, ALU);
    #2 chk("nf_w_stall", stall_f, 1);
    drain();

    // Link class gives no relief without bypassing
    drv(1, 0, 0, 0, 0, 0, 0, 1, 31, LINK);
    tick();
    drv(1, 31, 1, 1, 0, 0, 0, 0, 0, ALU);
    #2 chk("nf_jr_stall", stall_f, 1);
    chk("nf_jr_fwd_a_d", fwd_a_d, 0);
    drain();

    // Register 0 never hazards
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0, ALU);
    tick();
    drv(1, 0, 1, 0, 0, 1, 1, 0, 0, ALU);
    #2 chk("nf_r0_stall", stall_f, 0);
    drain();
`endif

    // Multiply: counter loads MUL_LAT, second start stalls while busy
    nop();
    issue_d = 1'b1; md_start_d = 1'b1; md_op_d = 1'b0;
    #2 chk("mul_start_nostall", stall_f, 0);
    tick();
    chk("mul_cnt_load", md_cnt, 5);
    chk("mul_busy", md_busy, 1);
    #2 chk("mul_busy_stall", stall_f, 1);
    tick();
    nop();
    chk("mul_cnt_no_reload", md_cnt, 4);
    repeat (4) tick();
    chk("mul_cnt_done", md_cnt, 0);
    chk("mul_busy_done", md_busy, 0);

    // Divide then mflo three cycles later: seven stall cycles
    issue_d = 1'b1; md_start_d = 1'b1; md_op_d = 1'b1;
    tick();
    nop();
    chk("div_cnt_load", md_cnt, 10);
    repeat (3) tick();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, ALU);
    md_use_d = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #2 chk("mflo_stall", stall_d, 1);
      chk("mflo_cnt", md_cnt, 7 - i);
      tick();
    end
    #2 chk("mflo_release", stall_d, 0);
    chk("mflo_cnt_zero", md_cnt, 0);
    tick();
    nop();

    // Reset in the middle of a divide countdown
    issue_d = 1'b1; md_start_d = 1'b1; md_op_d = 1'b1;
    tick();
    nop();
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 31, LINK);
    tick();
    drv(1, 31, 1, 1, 0, 0, 0, 0, 0, ALU);
    #2 chk("mid_cnt", md_cnt, 8);
    chk("mid_busy", md_busy, 1);
`ifdef HAZARD_FWD_EN
    chk("mid_fwd_a_d", fwd_a_d, 3);
    chk("mid_stall", stall_f, 0);
`else
    chk("mid_stall", stall_f, 1);
`endif
    rst_n = 1'b0;
    #1 chk("arst_cnt", md_cnt, 0);
    chk("arst_busy", md_busy, 0);
    chk("arst_stall", stall_f, 0);
    chk("arst_flush", flush_e, 0);
    chk("arst_fwd_a_d", fwd_a_d, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nop();
    tick();
    chk("post_rst_cnt", md_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
